// File: rtl/interval_capture.sv
// Measures enabled-clock intervals between rising edges of evt and queues them in a small FIFO.
// Optional macro CAPTURE_SYNC_EN inserts a 2-flop synchronizer on evt ahead of edge detection.
module interval_capture #(
  parameter int bits  = 16,
  parameter int depth = 4,
  parameter int lw    = 3
) (
  input  logic            c,
  input  logic            clr,
  input  logic            en,
  input  logic            evt,
  input  logic            rd,
  output logic [bits-1:0] out,
  output logic            sat,
  output logic            valid,
  output logic [lw-1:0]   level,
  output logic            ovf
);

  localparam int aw = lw - 1;
  localparam logic [bits-1:0] cnt_max    = {bits{1'b1}};
  localparam logic [lw-1:0]   level_full = lw'(depth);
  localparam logic [lw-1:0]   level_one  = lw'(1);
  localparam logic [lw-1:0]   level_zero = {lw{1'b0}};
  localparam logic [aw-1:0]   ptr_one    = aw'(1);

  logic            evt_s;
  logic            evt_q;
  logic            edge_det;
  logic            armed;
  logic [bits-1:0] cnt;
  logic [bits:0]   sample;
  logic            push_req;
  logic            do_push;
  logic            do_pop;
  logic            drop;
  logic            full;
  logic [lw-1:0]   level_next;
  logic [bits:0]   head_next;
  logic [bits:0]   mem [depth];
  logic [aw-1:0]   rd_ptr;
  logic [aw-1:0]   wr_ptr;

`ifdef CAPTURE_SYNC_EN
  logic [1:0] sync;

  // Two-flop synchronizer; evt may be asynchronous to c in this build.
  always_ff @(posedge c) begin
    if (clr) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], evt};
    end
  end

  assign evt_s = sync[1];
`else
  assign evt_s = evt;
`endif

  // Previous event level for rising-edge detection, tracked even while en=0.
  always_ff @(posedge c) begin
    if (clr) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= evt_s;
    end
  end

  assign edge_det = evt_s & ~evt_q;
  assign push_req = en & edge_det & armed;
  assign sample   = {(cnt == cnt_max), cnt};

  // Interval counter: the first edge after clr only arms; counting saturates instead of wrapping.
  always_ff @(posedge c) begin
    if (clr) begin
      armed <= 1'b0;
      cnt   <= {bits{1'b0}};
    end else if (en) begin
      if (edge_det) begin
        armed <= 1'b1;
        cnt   <= bits'(1);
      end else if (armed && (cnt != cnt_max)) begin
        cnt <= cnt + bits'(1);
      end
    end
  end

  assign full    = (level == level_full);
  assign do_pop  = rd & valid;
  assign do_push = push_req & (~full | do_pop);
  assign drop    = push_req & full & ~do_pop;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    level_next = level;
    case ({do_push, do_pop})
      2'b10:   level_next = level + lw'(1);
      2'b01:   level_next = level - lw'(1);
      default: level_next = level;
    endcase
  end

  // Next head entry; a full-FIFO push lands in the slot being popped, so rd_ptr+1 is untouched.
  always_comb begin
    head_next = {sat, out};
    if (do_pop) begin
      if (level == level_one) begin
        if (do_push) begin
          head_next = sample;
        end else begin
          head_next = {sat, out};
        end
      end else begin
        head_next = mem[rd_ptr + ptr_one];
      end
    end else if ((level == level_zero) && do_push) begin
      head_next = sample;
    end else begin
      head_next = {sat, out};
    end
  end

  // Sample storage.
  always_ff @(posedge c) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= sample;
    end
  end

  // FIFO pointers, registered head view and status flags.
  always_ff @(posedge c) begin
    if (clr) begin
      rd_ptr <= {aw{1'b0}};
      wr_ptr <= {aw{1'b0}};
      level  <= level_zero;
      out    <= {bits{1'b0}};
      sat    <= 1'b0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ptr_one;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ptr_one;
      end
      level      <= level_next;
      valid      <= (level_next != level_zero);
      {sat, out} <= head_next;
      ovf        <= ovf | drop;
    end
  end

endmodule

// File: tb/tb_interval_capture.sv
// Directed bench for interval_capture: a 16-bit instance and a 4-bit instance share one stimulus.
module tb_interval_capture;

`ifdef CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        c;
  logic        clr;
  logic        en;
  logic        evt;
  logic        rd;
  logic [15:0] out_a;
  logic        sat_a;
  logic        valid_a;
  logic [2:0]  level_a;
  logic        ovf_a;
  logic [3:0]  out_b;
  logic        sat_b;
  logic        valid_b;
  logic [2:0]  level_b;
  logic        ovf_b;

  int total  = 0;
  int passed = 0;

  interval_capture #(.bits(16), .depth(4), .lw(3)) dut_a (
    .c(c), .clr(clr), .en(en), .evt(evt), .rd(rd),
    .out(out_a), .sat(sat_a), .valid(valid_a), .level(level_a), .ovf(ovf_a)
  );

  interval_capture #(.bits(4), .depth(4), .lw(3)) dut_b (
    .c(c), .clr(clr), .en(en), .evt(evt), .rd(rd),
    .out(out_b), .sat(sat_b), .valid(valid_b), .level(level_b), .ovf(ovf_b)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic edge_tick();
    evt = 1'b1;
    tick();
    evt = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; evt = 1'b0; rd = 1'b0;
    idle(2);
    clr = 1'b0;

    // 1: reset state, first edge arms only, samples 20 and 25 in order
    chk("rst_out",   32'(out_a),   32'd0);
    chk("rst_sat",   32'(sat_a),   32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_level", 32'(level_a), 32'd0);
    chk("rst_ovf",   32'(ovf_a),   32'd0);
    en = 1'b1;
    edge_tick();
    idle(LAT);
    chk("t1_arm_only", 32'(valid_a), 32'd0);
    idle(19 - LAT);
    chk("t1_pre_valid", 32'(valid_a), 32'd0);
    edge_tick();
    idle(LAT);
    chk("t1_valid", 32'(valid_a), 32'd1);
    chk("t1_s0",    32'(out_a),   32'd20);
    chk("t1_lvl1",  32'(level_a), 32'd1);
    idle(24 - LAT);
    edge_tick();
    idle(LAT);
    chk("t1_lvl2", 32'(level_a), 32'd2);
    chk("t1_head", 32'(out_a),   32'd20);
    pop();
    chk("t1_s1",   32'(out_a),   32'd25);
    pop();
    chk("t1_empty", 32'(valid_a), 32'd0);
    chk("t1_lvl0",  32'(level_a), 32'd0);

    // 2: 4-bit saturation (interval 20 -> 15/sat), then interval 5
    clr_pulse();
    edge_tick();
    idle(19);
    edge_tick();
    idle(LAT);
    chk("t2_b_out", 32'(out_b), 32'd15);
    chk("t2_b_sat", 32'(sat_b), 32'd1);
    chk("t2_a_out", 32'(out_a), 32'd20);
    chk("t2_a_sat", 32'(sat_a), 32'd0);
    idle(4 - LAT);
    edge_tick();
    idle(LAT);
    chk("t2_b_lvl", 32'(level_b), 32'd2);
    pop();
    chk("t2_b_out5", 32'(out_b),   32'd5);
    chk("t2_b_sat0", 32'(sat_b),   32'd0);
    chk("t2_b_valid", 32'(valid_b), 32'd1);

    // 3: six intervals into depth 4, no reads -> first four kept, ovf sticky
    clr_pulse();
    edge_tick();
    for (int g = 3; g <= 8; g++) begin
      idle(g - 1);
      edge_tick();
    end
    idle(LAT);
    chk("t3_lvl",  32'(level_a), 32'd4);
    chk("t3_ovf",  32'(ovf_a),   32'd1);
    chk("t3_h3",   32'(out_a),   32'd3);
    pop();
    chk("t3_h4",   32'(out_a),   32'd4);
    pop();
    chk("t3_h5",   32'(out_a),   32'd5);
    pop();
    chk("t3_h6",   32'(out_a),   32'd6);
    pop();
    chk("t3_empty",  32'(valid_a), 32'd0);
    chk("t3_lvl0",   32'(level_a), 32'd0);
    chk("t3_ovf_st", 32'(ovf_a),   32'd1);

    // 4: full FIFO, push and pop in the same cycle
    clr_pulse();
    edge_tick();
    for (int g = 2; g <= 5; g++) begin
      idle(g - 1);
      edge_tick();
    end
    idle(LAT);
    chk("t4_full", 32'(level_a), 32'd4);
    chk("t4_ovf0", 32'(ovf_a),   32'd0);
    chk("t4_h2",   32'(out_a),   32'd2);
    idle(5 - LAT);
    evt = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      tick();
      evt = 1'b0;
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    evt = 1'b0;
    chk("t4_ovf", 32'(ovf_a),   32'd0);
    chk("t4_lvl", 32'(level_a), 32'd4);
    chk("t4_h3",  32'(out_a),   32'd3);
    pop();
    chk("t4_h4",  32'(out_a),   32'd4);
    pop();
    chk("t4_h5",  32'(out_a),   32'd5);
    pop();
    chk("t4_tail", 32'(out_a),   32'd6);
    chk("t4_lvl1", 32'(level_a), 32'd1);

    // 5: 10-cycle en=0 window inside a 20-cycle gap; edge in window ignored
    clr_pulse();
    edge_tick();
    idle(4);
    en = 1'b0;
    idle(3);
    edge_tick();
    idle(6);
    en = 1'b1;
    idle(5);
    edge_tick();
    idle(LAT);
    chk("t5_valid", 32'(valid_a), 32'd1);
    chk("t5_lvl",   32'(level_a), 32'd1);
    chk("t5_out",   32'(out_a),   32'd10);

    // 6: clr with level 3 and armed -> empty, next edge only arms
    idle(2);
    edge_tick();
    idle(3);
    edge_tick();
    idle(LAT);
    chk("t6_lvl3", 32'(level_a), 32'd3);
    clr_pulse();
    chk("t6_lvl0",  32'(level_a), 32'd0);
    chk("t6_valid", 32'(valid_a), 32'd0);
    chk("t6_ovf",   32'(ovf_a),   32'd0);
    chk("t6_out",   32'(out_a),   32'd0);
    edge_tick();
    idle(5);
    chk("t6_arm_only", 32'(valid_a), 32'd0);
    edge_tick();
    idle(LAT);
    chk("t6_valid1", 32'(valid_a), 32'd1);
    chk("t6_s6",     32'(out_a),   32'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
